// File: rtl/bus_arbiter_mux.sv
// Two-master bus arbiter with write mux and registered read-data steering.
// Define BUS_ARB_RR_EN to cap contested ownership at MAX_HOLD cycles.
module bus_arbiter_mux #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M0_req,
  input  logic              M0_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [DATA_W-1:0] M0_dout,
  input  logic              M1_req,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M1_dout,
  input  logic              S0_sel,
  input  logic              S1_sel,
  input  logic              S2_sel,
  input  logic              S3_sel,
  input  logic [DATA_W-1:0] S0_dout,
  input  logic [DATA_W-1:0] S1_dout,
  input  logic [DATA_W-1:0] S2_dout,
  input  logic [DATA_W-1:0] S3_dout,
  output logic              M0_grant,
  output logic              M1_grant,
  output logic [ADDR_W-1:0] M_addr,
  output logic              M_wr,
  output logic [DATA_W-1:0] M_dout,
  output logic [DATA_W-1:0] M_din
);

  if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_cfg
    $error("bus_arbiter_mux: CNT_W too narrow for MAX_HOLD");
  end

  typedef enum logic {
    M0_OWN = 1'b0,
    M1_OWN = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       m0_grant_q;
  logic       m1_grant_q;
  logic [3:0] sel_q;
  logic       own_req;
  logic       oth_req;
  logic       hand_off;

`ifdef BUS_ARB_RR_EN
  logic [CNT_W-1:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d  = state_q;
    own_req  = (state_q == M0_OWN) ? M0_req : M1_req;
    oth_req  = (state_q == M0_OWN) ? M1_req : M0_req;
    // M0 is the parked owner, so M1 drops the bus as soon as it stops asking
    hand_off = (state_q == M0_OWN) ? (!M0_req && M1_req) : !M1_req;
`ifdef BUS_ARB_RR_EN
    hold_d = '0;
    if (own_req && oth_req) begin
      if (hold_q == CNT_W'(MAX_HOLD - 1)) begin
        hand_off = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
    if (hand_off) begin
      hold_d = '0;
    end
`endif
    if (hand_off) begin
      state_d = (state_q == M0_OWN) ? M1_OWN : M0_OWN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= M0_OWN;
      m0_grant_q <= 1'b1;
      m1_grant_q <= 1'b0;
      sel_q      <= 4'b0000;
`ifdef BUS_ARB_RR_EN
      hold_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      m0_grant_q <= (state_d == M0_OWN);
      m1_grant_q <= (state_d == M1_OWN);
      sel_q      <= {S0_sel, S1_sel, S2_sel, S3_sel};
`ifdef BUS_ARB_RR_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign M0_grant = m0_grant_q;
  assign M1_grant = m1_grant_q;

  always_comb begin
    if (m1_grant_q) begin
      M_addr = M1_address;
      M_dout = M1_dout;
      M_wr   = M1_wr && M1_req;
    end else begin
      M_addr = M0_address;
      M_dout = M0_dout;
      M_wr   = M0_wr && M0_req;
    end
  end

  // sel_q[3] is S0; lower slave index wins on an illegal multi-hot select
  always_comb begin
    if (sel_q[3]) begin
      M_din = S0_dout;
    end else if (sel_q[2]) begin
      M_din = S1_dout;
    end else if (sel_q[1]) begin
      M_din = S2_dout;
    end else if (sel_q[0]) begin
      M_din = S3_dout;
    end else begin
      M_din = '0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux with a small nibble address decoder.
// Contention checks follow BUS_ARB_RR_EN when it is defined.
module tb_bus_arbiter_mux;

  logic        clk;
  logic        reset_n;
  logic        M0_req, M0_wr, M1_req, M1_wr;
  logic [7:0]  M0_address, M1_address;
  logic [31:0] M0_dout, M1_dout;
  logic        S0_sel, S1_sel, S2_sel, S3_sel;
  logic [31:0] S0_dout, S1_dout, S2_dout, S3_dout;
  logic        M0_grant, M1_grant, M_wr;
  logic [7:0]  M_addr;
  logic [31:0] M_dout, M_din;
  logic        multi;

  int n_chk;
  int n_fail;

  bus_arbiter_mux dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .M0_req    (M0_req),
    .M0_wr     (M0_wr),
    .M0_address(M0_address),
    .M0_dout   (M0_dout),
    .M1_req    (M1_req),
    .M1_wr     (M1_wr),
    .M1_address(M1_address),
    .M1_dout   (M1_dout),
    .S0_sel    (S0_sel),
    .S1_sel    (S1_sel),
    .S2_sel    (S2_sel),
    .S3_sel    (S3_sel),
    .S0_dout   (S0_dout),
    .S1_dout   (S1_dout),
    .S2_dout   (S2_dout),
    .S3_dout   (S3_dout),
    .M0_grant  (M0_grant),
    .M1_grant  (M1_grant),
    .M_addr    (M_addr),
    .M_wr      (M_wr),
    .M_dout    (M_dout),
    .M_din     (M_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0x0X->S0, 0x2X->S1, 0x3X->S2, 0x4X->S3, others unmapped
  always_comb begin
    S0_sel = 1'b0;
    S1_sel = 1'b0;
    S2_sel = 1'b0;
    S3_sel = 1'b0;
    case (M_addr[7:4])
      4'h0: S0_sel = 1'b1;
      4'h2: S1_sel = 1'b1;
      4'h3: S2_sel = 1'b1;
      4'h4: S3_sel = 1'b1;
      default: ;
    endcase
    if (multi) begin
      S0_sel = 1'b1;
      S2_sel = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    multi = 1'b0;
    M0_req = 1'b0; M0_wr = 1'b0; M0_address = 8'h00; M0_dout = 32'h0;
    M1_req = 1'b0; M1_wr = 1'b0; M1_address = 8'h00; M1_dout = 32'h0;
    S0_dout = 32'hA5A5A5A5;
    S1_dout = 32'h11111111;
    S2_dout = 32'h22222222;
    S3_dout = 32'h3C3C3C3C;

    #12;
    chk("rst_g0", {31'd0, M0_grant}, 32'd1);
    chk("rst_g1", {31'd0, M1_grant}, 32'd0);
    chk("rst_din", M_din, 32'd0);

    // read from S0 by parked owner M0
    @(negedge clk);
    reset_n = 1'b1;
    M0_req = 1'b1;
    M0_address = 8'h05;
    #1 chk("t1_addr", {24'd0, M_addr}, 32'h05);
    @(negedge clk);
    chk("t1_g0", {31'd0, M0_grant}, 32'd1);
    chk("t1_din", M_din, 32'hA5A5A5A5);

    // hand over to M1; M0 owner not requesting must not write
    M0_req = 1'b0;
    M0_wr = 1'b1;
    M1_req = 1'b1;
    M1_wr = 1'b1;
    M1_address = 8'h23;
    M1_dout = 32'hDEADBEEF;
    #1;
    chk("t2_g1_pre", {31'd0, M1_grant}, 32'd0);
    chk("t2_wr_pre", {31'd0, M_wr}, 32'd0);
    @(negedge clk);
    chk("t2_g1", {31'd0, M1_grant}, 32'd1);
    chk("t2_g0", {31'd0, M0_grant}, 32'd0);
    chk("t2_addr", {24'd0, M_addr}, 32'h23);
    chk("t2_wr", {31'd0, M_wr}, 32'd1);
    chk("t2_dout", M_dout, 32'hDEADBEEF);
    chk("t2_din_old", M_din, 32'hA5A5A5A5);
    @(negedge clk);
    chk("t2_din", M_din, 32'h11111111);

    // M1 drops req with wr still high
    M1_req = 1'b0;
    M0_wr = 1'b0;
    #1;
    chk("t5_wr", {31'd0, M_wr}, 32'd0);
    chk("t5_g1_hold", {31'd0, M1_grant}, 32'd1);
    @(negedge clk);
    chk("t5_g0", {31'd0, M0_grant}, 32'd1);
    chk("t5_addr", {24'd0, M_addr}, 32'h05);

    // unmapped and S3 reads
    M0_req = 1'b1;
    M0_address = 8'h70;
    @(negedge clk);
    chk("t4_unmapped", M_din, 32'd0);
    M0_address = 8'h45;
    @(negedge clk);
    chk("t4_s3", M_din, 32'h3C3C3C3C);

    // illegal multi-hot select: lowest index wins
    multi = 1'b1;
    @(negedge clk);
    chk("multi_hot", M_din, 32'hA5A5A5A5);
    multi = 1'b0;

    // both masters request for 20 cycles, M0 owns at start
    M1_req = 1'b1;
    M1_wr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic exp_g0;
      @(negedge clk);
`ifdef BUS_ARB_RR_EN
      exp_g0 = ((k / 8) % 2) == 0;
`else
      exp_g0 = 1'b1;
`endif
      chk($sformatf("t3_g0_c%0d", k), {31'd0, M0_grant}, {31'd0, exp_g0});
      chk($sformatf("t3_g1_c%0d", k), {31'd0, M1_grant}, {31'd0, !exp_g0});
    end

    // M1 writing to S1, then async reset mid-cycle
    M0_req = 1'b0;
    M1_req = 1'b1;
    M1_wr = 1'b1;
    M1_address = 8'h23;
    @(negedge clk);
    @(negedge clk);
    chk("t6_g1_pre", {31'd0, M1_grant}, 32'd1);
    chk("t6_din_pre", M_din, 32'h11111111);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_g1", {31'd0, M1_grant}, 32'd0);
    chk("t6_g0", {31'd0, M0_grant}, 32'd1);
    chk("t6_din", M_din, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("t6_din_post", M_din, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
